// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the 5-stage pipeline sequencing controller and the
// stage registers it drives:
//   state_e     : controller FSM states (RUN / MEM_WAIT)
//   hz_ctrl_t   : bundle of the six freeze/flush controls
//   REG_ZERO    : architectural zero register index (never a hazard source)
//   RA_W_DEF    : default register-address width
//   ctrl_*()    : canned control patterns used by the priority mux
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

   localparam int RA_W_DEF = 5;
   localparam int REG_ZERO = 0;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic pc_freeze;
      logic if_id_freeze;
      logic if_id_flush;
      logic id_exe_flush;
      logic exe_mem_freeze;
      logic mem_wb_flush;
   } hz_ctrl_t;

   // No freeze, no flush: pipeline advances normally.
   function automatic hz_ctrl_t ctrl_idle();
      hz_ctrl_t c;
      c.pc_freeze      = 1'b0;
      c.if_id_freeze   = 1'b0;
      c.if_id_flush    = 1'b0;
      c.id_exe_flush   = 1'b0;
      c.exe_mem_freeze = 1'b0;
      c.mem_wb_flush   = 1'b0;
      return c;
   endfunction

   // Reset drain: every stage register loads a NOP, nothing is held.
   function automatic hz_ctrl_t ctrl_drain();
      hz_ctrl_t c;
      c              = ctrl_idle();
      c.if_id_flush  = 1'b1;
      c.id_exe_flush = 1'b1;
      c.mem_wb_flush = 1'b1;
      return c;
   endfunction

   // Memory wait: everything up to EXE/MEM holds, WB receives bubbles.
   function automatic hz_ctrl_t ctrl_mem_stall();
      hz_ctrl_t c;
      c                = ctrl_idle();
      c.pc_freeze      = 1'b1;
      c.if_id_freeze   = 1'b1;
      c.exe_mem_freeze = 1'b1;
      c.mem_wb_flush   = 1'b1;
      return c;
   endfunction

   // Taken branch: discard the two wrong-path instructions in IF and ID.
   function automatic hz_ctrl_t ctrl_branch();
      hz_ctrl_t c;
      c              = ctrl_idle();
      c.if_id_flush  = 1'b1;
      c.id_exe_flush = 1'b1;
      return c;
   endfunction

   // Data hazard: hold PC and IF/ID, inject one bubble into ID/EXE.
   function automatic hz_ctrl_t ctrl_bubble();
      hz_ctrl_t c;
      c              = ctrl_idle();
      c.pc_freeze    = 1'b1;
      c.if_id_freeze = 1'b1;
      c.id_exe_flush = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : datapath side - drives the stage fields, receives the controls
//   slave  : controller side - reads the stage fields, drives the controls
// Stage fields : id_src1/2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
//                exe_br_taken, mem_dest, mem_wb_en, mem_acc, mem_ready
// Controls     : pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
//                exe_mem_freeze, mem_wb_flush
// Status       : mem_timeout (sticky), stall_cnt, flush_cnt (saturating)
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
);

   logic [RA_W-1:0]  id_src1;
   logic [RA_W-1:0]  id_src2;
   logic             id_two_src;
   logic [RA_W-1:0]  exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   logic             exe_br_taken;
   logic [RA_W-1:0]  mem_dest;
   logic             mem_wb_en;
   logic             mem_acc;
   logic             mem_ready;

   logic             pc_freeze;
   logic             if_id_freeze;
   logic             if_id_flush;
   logic             id_exe_flush;
   logic             exe_mem_freeze;
   logic             mem_wb_flush;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
             exe_br_taken, mem_dest, mem_wb_en, mem_acc, mem_ready,
      input  pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
             exe_mem_freeze, mem_wb_flush, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
             exe_br_taken, mem_dest, mem_wb_en, mem_acc, mem_ready,
      output pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
             exe_mem_freeze, mem_wb_flush, mem_timeout, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_mem_wait_timer
// Bounds how long a data-memory access may freeze the pipeline.
//   clk, rst        : clock, synchronous active-low reset
//   mem_acc         : MEM stage is accessing data memory
//   mem_ready       : memory completes the access this cycle
//   mem_stall       : freeze request (access pending and budget left)
//   timeout_reached : budget exhausted (wait_cnt == MEM_TIMEOUT)
//   mem_timeout     : sticky flag, set when an access is aborted
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_acc,
   input  logic mem_ready,
   output logic mem_stall,
   output logic timeout_reached,
   output logic mem_timeout
);

   localparam int              WC_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

   logic [WC_W-1:0] wait_cnt_q;
   logic [WC_W-1:0] wait_cnt_d;
   logic            mem_timeout_q;
   logic            mem_timeout_d;
   logic            abort_s;

   // Stall request, abort detection and next wait count.
   always_comb begin
      timeout_reached = (wait_cnt_q == WC_MAX);
      mem_stall       = bus_pending(mem_acc, mem_ready) && (wait_cnt_q < WC_MAX);
      // The access is still pending but the budget is spent: release the
      // pipeline this cycle and remember that data was lost.
      abort_s         = bus_pending(mem_acc, mem_ready) && timeout_reached;
      wait_cnt_d      = wait_cnt_q;
      if (mem_stall) begin
         wait_cnt_d = wait_cnt_q + WC_W'(1);
      end else if (mem_ready || timeout_reached) begin
         // Leaving MEM_WAIT (completion or abort) restarts the budget.
         wait_cnt_d = {WC_W{1'b0}};
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
      mem_timeout_d = mem_timeout_q | abort_s;
   end

   // Wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt_q    <= {WC_W{1'b0}};
         mem_timeout_q <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout = mem_timeout_q;

   function automatic logic bus_pending(input logic acc, input logic rdy);
      return acc & ~rdy;
   endfunction

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Sequencing controller for the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
// Detects RAW hazards, taken branches and multi-cycle memory accesses and
// drives the freeze/flush controls with zero latency; keeps saturating
// stall/flush statistics and a sticky memory-timeout flag.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-low (controls drain the pipe while low)
//   bus  : pipeline_hazard_ctrl_if.slave (stage fields in, controls/status out)
// Parameters: RA_W, FWD_EN (1: only load-use stalls), MEM_TIMEOUT, CNT_W
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int RA_W        = RA_W_DEF,
   parameter int FWD_EN      = 1,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_hazard_ctrl_if.slave  bus
);

   localparam logic [RA_W-1:0]  ZERO_REG = RA_W'(REG_ZERO);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_e           state_q;
   state_e           state_d;
   hz_ctrl_t         ctrl_s;
   logic             raw_exe_s;
   logic             raw_mem_s;
   logic             data_haz_s;
   logic             mem_stall_s;
   logic             timeout_reached_s;
   logic             mem_timeout_s;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d;

   pipeline_hazard_ctrl_mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .clk             (clk),
      .rst             (rst),
      .mem_acc         (bus.mem_acc),
      .mem_ready       (bus.mem_ready),
      .mem_stall       (mem_stall_s),
      .timeout_reached (timeout_reached_s),
      .mem_timeout     (mem_timeout_s)
   );

   // RAW detection against the producers in EXE and MEM.
   always_comb begin
      // A non-zero dest that equals a source implies the source is non-zero,
      // so r0 can never raise a hazard.
      raw_exe_s = bus.exe_wb_en && (bus.exe_dest != ZERO_REG) &&
                  ((bus.exe_dest == bus.id_src1) ||
                   (bus.id_two_src && (bus.exe_dest == bus.id_src2)));
      raw_mem_s = bus.mem_wb_en && (bus.mem_dest != ZERO_REG) &&
                  ((bus.mem_dest == bus.id_src1) ||
                   (bus.id_two_src && (bus.mem_dest == bus.id_src2)));
      if (FWD_EN != 0) begin
         // Forwarding covers everything except a load still in EXE.
         data_haz_s = raw_exe_s && bus.exe_mem_r_en;
      end else begin
         data_haz_s = raw_exe_s || raw_mem_s;
      end
   end

   // Priority mux: reset drain > memory wait > taken branch > data hazard.
   always_comb begin
      ctrl_s = ctrl_idle();
      if (!rst) begin
         ctrl_s = ctrl_drain();
      end else if (mem_stall_s) begin
         // Branch and data hazards stay on held inputs and resolve later.
         ctrl_s = ctrl_mem_stall();
      end else if (bus.exe_br_taken) begin
         // The ID instruction is wrong-path, so its hazard is irrelevant.
         ctrl_s = ctrl_branch();
      end else if (data_haz_s) begin
         ctrl_s = ctrl_bubble();
      end else begin
         ctrl_s = ctrl_idle();
      end
   end

   // FSM next state: track whether a memory access is being waited on.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (mem_stall_s) begin
               state_d = ST_MEM_WAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_ready || timeout_reached_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_MEM_WAIT;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Saturating statistics; branch flushes only count outside reset drain.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (ctrl_s.pc_freeze && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (ctrl_s.if_id_flush && rst && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // State and statistics registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.pc_freeze      = ctrl_s.pc_freeze;
   assign bus.if_id_freeze   = ctrl_s.if_id_freeze;
   assign bus.if_id_flush    = ctrl_s.if_id_flush;
   assign bus.id_exe_flush   = ctrl_s.id_exe_flush;
   assign bus.exe_mem_freeze = ctrl_s.exe_mem_freeze;
   assign bus.mem_wb_flush   = ctrl_s.mem_wb_flush;
   assign bus.mem_timeout    = mem_timeout_s;
   assign bus.stall_cnt      = stall_cnt_q;
   assign bus.flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scoreboard bench: the driver applies one input vector per cycle and
// queues the hand-derived expected controls/status; a negedge monitor pops and
// compares. Counters use CNT_W=4 so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int RA_W        = 5;
   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 15;

   // Control order: {pc_f, if_id_f, if_id_fl, id_exe_fl, exe_mem_f, mem_wb_fl}
   localparam logic [5:0] C_IDLE  = 6'b000000;
   localparam logic [5:0] C_DRAIN = 6'b001101;
   localparam logic [5:0] C_BUB   = 6'b110100;
   localparam logic [5:0] C_BR    = 6'b001100;
   localparam logic [5:0] C_MEM   = 6'b110011;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();

   pipeline_hazard_ctrl #(
      .RA_W        (RA_W),
      .FWD_EN      (1),
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string            name;
      logic [5:0]       ctrl;
      logic             chk_cnt;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
      logic             to;
   } exp_t;

   exp_t             sb_q[$];
   int               n_checks = 0;
   int               n_pass   = 0;
   logic [CNT_W-1:0] m_stall  = '0;
   logic [CNT_W-1:0] m_flush  = '0;
   logic             m_to     = 1'b0;
   logic             m_valid  = 1'b0;

   task automatic check(input string what, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", what, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t       e;
      logic [5:0] act;
      if (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         act = {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush,
                bus.id_exe_flush, bus.exe_mem_freeze, bus.mem_wb_flush};
         check({e.name, "/ctrl"}, 16'(act), 16'(e.ctrl));
         if (e.chk_cnt) begin
            check({e.name, "/stall_cnt"}, 16'(bus.stall_cnt), 16'(e.stall));
            check({e.name, "/flush_cnt"}, 16'(bus.flush_cnt), 16'(e.flush));
            check({e.name, "/mem_timeout"}, 16'(bus.mem_timeout), 16'(e.to));
         end
      end
   end

   task automatic set_in(input int s1, input int s2, input logic two,
                         input int ed, input logic ewb, input logic emr,
                         input logic br, input int md, input logic mwb,
                         input logic acc, input logic rdy);
      bus.id_src1      = RA_W'(s1);
      bus.id_src2      = RA_W'(s2);
      bus.id_two_src   = two;
      bus.exe_dest     = RA_W'(ed);
      bus.exe_wb_en    = ewb;
      bus.exe_mem_r_en = emr;
      bus.exe_br_taken = br;
      bus.mem_dest     = RA_W'(md);
      bus.mem_wb_en    = mwb;
      bus.mem_acc      = acc;
      bus.mem_ready    = rdy;
   endtask

   task automatic idle_in();
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   // Queue the expectation for this cycle, then advance the expected status.
   task automatic cyc(input string name, input logic [5:0] ctrl, input logic set_to);
      exp_t e;
      e.name    = name;
      e.ctrl    = ctrl;
      e.chk_cnt = m_valid;
      e.stall   = m_stall;
      e.flush   = m_flush;
      e.to      = m_to;
      sb_q.push_back(e);
      if (rst == 1'b0) begin
         m_stall = '0;
         m_flush = '0;
         m_to    = 1'b0;
         m_valid = 1'b1;
      end else begin
         if (ctrl[5] && (m_stall != '1)) m_stall = m_stall + 1'b1;
         if (ctrl[3] && (m_flush != '1)) m_flush = m_flush + 1'b1;
         if (set_to) m_to = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      idle_in();
      @(posedge clk);
      #1;
      // Reset drain
      cyc("rst_a", C_DRAIN, 1'b0);
      cyc("rst_b", C_DRAIN, 1'b0);
      rst = 1'b1;
      // Load-use on src1, then idle shows stall_cnt=1
      set_in(5, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      cyc("load_use", C_BUB, 1'b0);
      idle_in();
      cyc("after_lu", C_IDLE, 1'b0);
      // ALU RAW is forwarded: no stall
      set_in(5, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      cyc("alu_raw", C_IDLE, 1'b0);
      // Load-use through src2
      set_in(3, 9, 1'b1, 9, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      cyc("lu_src2", C_BUB, 1'b0);
      // r0 never hazards
      set_in(0, 0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      cyc("reg0", C_IDLE, 1'b0);
      // src2 ignored for single-source instruction
      set_in(3, 5, 1'b0, 5, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      cyc("one_src", C_IDLE, 1'b0);
      // MEM-stage producer is forwarded
      set_in(7, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b0);
      cyc("mem_raw", C_IDLE, 1'b0);
      // Branch beats load-use
      set_in(5, 0, 1'b0, 5, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      cyc("br_vs_haz", C_BR, 1'b0);
      idle_in();
      cyc("after_br", C_IDLE, 1'b0);
      // Memory wait of 3 cycles with a held branch deferred until release
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc("mem_wait", C_MEM, 1'b0);
      bus.mem_ready = 1'b1;
      cyc("mem_done_br", C_BR, 1'b0);
      idle_in();
      cyc("after_mem", C_IDLE, 1'b0);
      // Ready together with access: no stall
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
      cyc("mem_fast", C_IDLE, 1'b0);
      // Timeout: 15 frozen cycles, abort on the 16th; stall_cnt saturates
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < MEM_TIMEOUT; i++) cyc("to_wait", C_MEM, 1'b0);
      cyc("to_abort", C_IDLE, 1'b1);
      idle_in();
      cyc("after_abort", C_IDLE, 1'b0);
      // Next access starts with a fresh budget; flag stays sticky
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      cyc("wait_again", C_MEM, 1'b0);
      bus.mem_ready = 1'b1;
      cyc("done_again", C_IDLE, 1'b0);
      idle_in();
      cyc("sticky_to", C_IDLE, 1'b0);
      // Reset in the middle of a memory wait
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      cyc("pre_rst_w", C_MEM, 1'b0);
      cyc("pre_rst_w", C_MEM, 1'b0);
      rst = 1'b0;
      cyc("rst_mid", C_DRAIN, 1'b0);
      rst = 1'b1;
      idle_in();
      cyc("post_rst", C_IDLE, 1'b0);
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      cyc("post_rst_w", C_MEM, 1'b0);
      bus.mem_ready = 1'b1;
      cyc("post_rst_d", C_IDLE, 1'b0);
      idle_in();
      cyc("final", C_IDLE, 1'b0);
      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      #2;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
